// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan driver.
package sevenseg_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [3:0] AN_OFF     = 4'b1111;

   typedef logic [1:0] digit_idx_t;

   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  blank;
   } disp_t;

   // True when nibble idx and every nibble above it are zero.
   function automatic logic upper_zero(input logic [15:0] value, input digit_idx_t idx);
      return (value >> {idx, 2'b00}) == 16'd0;
   endfunction

endpackage

// File: rtl/sevenseg_scan_driver_scan_timer.sv
// Slot counter and digit index for the scan driver. slot_start, dead and sel_next
// describe the upcoming cycle, so registered outputs fed from them line up with cnt.
module scan_timer
   import sevenseg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic       slot_start,
   output logic       dead,
   output logic       frame_wrap,
   output digit_idx_t digit_sel,
   output digit_idx_t sel_next
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          slot_end;

   // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
   always_comb begin
      slot_end   = (cnt == CW'(REFRESH_DIV - 1));
      cnt_next   = slot_end ? '0 : cnt + CW'(1);
      sel_next   = slot_end ? digit_sel + 2'd1 : digit_sel;
      slot_start = slot_end;
      dead       = (cnt_next < CW'(DEAD_CYCLES));
      frame_wrap = slot_end && (digit_sel == 2'(NUM_DIGITS - 1));
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         digit_sel <= '0;
      end else begin
         cnt       <= cnt_next;
         digit_sel <= sel_next;
      end
   end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver: double-buffered display contents
// committed at frame boundaries, blanking, leading-zero suppression and dead time.
module sevenseg_scan_driver
   import sevenseg_pkg::*;
#(
   parameter int REFRESH_DIV   = 100000,
   parameter int DEAD_CYCLES   = 4,
   parameter int BLANK_LEADING = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic [3:0]  blank,
   input  logic        load,
   output logic [3:0]  nibble,
   output logic [3:0]  an,
   output logic        dp_n,
   output logic [1:0]  digit_sel,
   output logic        pending,
   output logic        frame_tick
);

   logic                  slot_start;
   logic                  dead;
   logic                  frame_wrap;
   digit_idx_t            sel_next;
   disp_t                 load_data;
   disp_t                 pend_q;
   disp_t                 disp_q;
   disp_t                 disp_next;
   logic [NUM_DIGITS-1:0] vis;

   scan_timer #(
      .REFRESH_DIV (REFRESH_DIV),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .slot_start (slot_start),
      .dead       (dead),
      .frame_wrap (frame_wrap),
      .digit_sel  (digit_sel),
      .sel_next   (sel_next)
   );

   assign load_data = '{value: value, dp: dp, blank: blank};

   // A load on the boundary cycle bypasses the pending buffer entirely.
   always_comb begin
      disp_next = disp_q;
      if (frame_wrap) begin
         if (load)         disp_next = load_data;
         else if (pending) disp_next = pend_q;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         vis[i] = !disp_next.blank[i] &&
                  !((BLANK_LEADING != 0) && (i != 0) &&
                    upper_zero(disp_next.value, digit_idx_t'(i)));
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the buffers are plain registers, so they are cleared on reset like any other state.
      if (reset) begin
         pend_q     <= '0;
         disp_q     <= '0;
         pending    <= 1'b0;
         nibble     <= 4'd0;
         an         <= AN_OFF;
         dp_n       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         disp_q     <= disp_next;
         frame_tick <= frame_wrap;

         if (frame_wrap) begin
            pending <= 1'b0;
         end else if (load) begin
            pend_q  <= load_data;
            pending <= 1'b1;
         end

         if (slot_start)
            nibble <= disp_next.value[{sel_next, 2'b00} +: 4];

         if (dead || !vis[sel_next]) begin
            an   <= AN_OFF;
            dp_n <= 1'b1;
         end else begin
            an   <= ~(4'b0001 << sel_next);
            dp_n <= ~disp_next.dp[sel_next];
         end
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed self-checking bench for sevenseg_scan_driver with REFRESH_DIV=8, DEAD_CYCLES=2.
module tb_sevenseg_scan_driver;

   localparam int RD = 8;
   localparam int DC = 2;

   logic        clk;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        load;
   logic [3:0]  nibble;
   logic [3:0]  an;
   logic        dp_n;
   logic [1:0]  digit_sel;
   logic        pending;
   logic        frame_tick;

   int n_cmp = 0;
   int n_bad = 0;

   sevenseg_scan_driver #(
      .REFRESH_DIV   (RD),
      .DEAD_CYCLES   (DC),
      .BLANK_LEADING (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .dp         (dp),
      .blank      (blank),
      .load       (load),
      .nibble     (nibble),
      .an         (an),
      .dp_n       (dp_n),
      .digit_sel  (digit_sel),
      .pending    (pending),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value = v;
      dp    = d;
      blank = b;
      load  = 1'b1;
      step();
      load  = 1'b0;
   endtask

   task automatic wait_tick();
      int k = 0;
      while (frame_tick !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      check("frame_tick_wait", 16'(frame_tick), 16'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " an"},         16'(an),         16'hF);
      check({tag, " dp_n"},       16'(dp_n),       16'd1);
      check({tag, " nibble"},     16'(nibble),     16'd0);
      check({tag, " digit_sel"},  16'(digit_sel),  16'd0);
      check({tag, " pending"},    16'(pending),    16'd0);
      check({tag, " frame_tick"}, 16'(frame_tick), 16'd0);
   endtask

   // Walks one whole frame from its first cycle; ends on the first cycle of the next frame.
   task automatic check_frame(input string tag, input logic [15:0] nibs, input logic [15:0] ans,
                              input logic [3:0] dpm, input logic first_tick);
      logic [3:0] e_an;
      logic       e_dpn;
      logic       e_tick;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < RD; c++) begin
            e_an   = (c < DC) ? 4'hF : ans[4*s +: 4];
            e_dpn  = (c >= DC && dpm[s]) ? 1'b0 : 1'b1;
            e_tick = (s == 0 && c == 0) ? first_tick : 1'b0;
            check($sformatf("%s s%0d c%0d an", tag, s, c),     16'(an),         16'(e_an));
            check($sformatf("%s s%0d c%0d dp_n", tag, s, c),   16'(dp_n),       16'(e_dpn));
            check($sformatf("%s s%0d c%0d nibble", tag, s, c), 16'(nibble),     16'(nibs[4*s +: 4]));
            check($sformatf("%s s%0d c%0d sel", tag, s, c),    16'(digit_sel),  16'(s));
            check($sformatf("%s s%0d c%0d tick", tag, s, c),   16'(frame_tick), 16'(e_tick));
            check($sformatf("%s s%0d c%0d pend", tag, s, c),   16'(pending),    16'd0);
            step();
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      load  = 1'b0;
      value = 16'h0;
      dp    = 4'h0;
      blank = 4'h0;
      step(3);
      check_reset_values("reset");
      reset = 1'b0;
      check_frame("post_reset", 16'h0000, 16'hFFFE, 4'b0000, 1'b0);

      do_load(16'h1234, 4'b0100, 4'b0000);
      check("basic pending", 16'(pending), 16'd1);
      wait_tick();
      check_frame("basic", 16'h1234, 16'h7BDE, 4'b0100, 1'b1);

      do_load(16'h0050, 4'b0000, 4'b0000);
      wait_tick();
      check_frame("lead_zero", 16'h0050, 16'hFFDE, 4'b0000, 1'b1);

      do_load(16'h0050, 4'b0000, 4'b0010);
      wait_tick();
      check_frame("blank", 16'h0050, 16'hFFFE, 4'b0000, 1'b1);

      step(5);
      do_load(16'hAAAA, 4'b0000, 4'b0000);
      step(1);
      do_load(16'hBBBB, 4'b0000, 4'b0000);
      check("double pending", 16'(pending), 16'd1);
      wait_tick();
      check_frame("double", 16'hBBBB, 16'h7BDE, 4'b0000, 1'b1);

      step(RD * 4 - 1);
      check("boundary sel", 16'(digit_sel), 16'd3);
      do_load(16'h9876, 4'b0000, 4'b0000);
      check("boundary pending", 16'(pending), 16'd0);
      check_frame("boundary", 16'h9876, 16'h7BDE, 4'b0000, 1'b1);

      do_load(16'h5555, 4'b1111, 4'b0000);
      step(2 * RD - 1);
      check("midreset pending", 16'(pending), 16'd1);
      check("midreset sel", 16'(digit_sel), 16'd2);
      reset = 1'b1;
      step();
      check_reset_values("midreset");
      reset = 1'b0;
      check_frame("after_midreset", 16'h0000, 16'hFFFE, 4'b0000, 1'b0);
      check_frame("after_midreset2", 16'h0000, 16'hFFFE, 4'b0000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
